// File: rtl/pmem_arb_types.sv
// -----------------------------------------------------------------------------
// pmem_arb_types
//   Shared types and default widths for the physical-memory arbiter.
//   Contents:
//     PMEM_ADDR_W_DEFAULT  default line-address width
//     PMEM_LINE_W_DEFAULT  default cache-line width in bits
//     arb_state_e          arbiter FSM state encoding
// -----------------------------------------------------------------------------
package pmem_arb_types;

  localparam int PMEM_ADDR_W_DEFAULT = 32;
  localparam int PMEM_LINE_W_DEFAULT = 256;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

endpackage : pmem_arb_types

// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
//   Shares one physical-memory port between the instruction cache (I side)
//   and the data-side victim cache (D side). One line transfer is in flight
//   at a time; each transfer is followed by a single RELEASE cycle so that a
//   client lowering its request after its resp is never served twice.
//
//   Configuration macro:
//     PMEM_ARB_ROUND_ROBIN_EN  defined   : simultaneous requests go to the
//                                          client not served last
//                              undefined : fixed priority, D side wins
//
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     i_addr, i_read        I-side line address / read request
//     i_rdata, i_resp       I-side returned line / one-cycle completion
//     d_addr, d_read,       D-side line address / read request /
//     d_write, d_wdata        write (eviction) request / write line
//     d_rdata, d_resp       D-side returned line / one-cycle completion
//     pmem_addr, pmem_read, physical memory address and strobes
//     pmem_write, pmem_wdata  (strobes held until pmem_resp), write line
//     pmem_rdata, pmem_resp physical memory read line and completion
// -----------------------------------------------------------------------------
module pmem_arbiter
  import pmem_arb_types::*;
#(
  parameter int ADDR_W = PMEM_ADDR_W_DEFAULT,
  parameter int LINE_W = PMEM_LINE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic [ADDR_W-1:0] pmem_addr,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_e state_q, state_d;
  logic       i_req;
  logic       d_req;
  logic       grant_d;   // meaningful only while some request is present

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  // Set when the D side received the most recent grant. Reset clears it so
  // the first contested grant goes to the D side.
  logic last_d_q, last_d_d;

  assign grant_d  = d_req & (~i_req | ~last_d_q);
  assign last_d_d = (state_q == ST_IDLE && (i_req || d_req)) ? grant_d : last_d_q;

  always_ff @(posedge clk) begin
    if (rst) last_d_q <= 1'b0;
    else     last_d_q <= last_d_d;
  end
`else
  assign grant_d = d_req;
`endif

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) state_d = grant_d ? ST_SERVE_D : ST_SERVE_I;
      end
      ST_SERVE_I,
      ST_SERVE_D: begin
        if (pmem_resp) state_d = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State register; reset wins even in the middle of a service.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Strobes decode straight from the registered state. Responses follow
  // pmem_resp in the same cycle, and pmem_resp outside a service state has
  // no effect anywhere.
  always_comb begin
    pmem_addr  = i_addr;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state_q)
      ST_SERVE_I: begin
        pmem_read = 1'b1;
        i_resp    = pmem_resp;
      end
      ST_SERVE_D: begin
        pmem_addr  = d_addr;
        // Read and write together is an eviction: the write takes it.
        pmem_write = d_write;
        pmem_read  = d_read & ~d_write;
        d_resp     = pmem_resp;
      end
      default: ;
    endcase
  end

  // Data paths are plain wires; only the resp strobes are gated by grant.
  assign pmem_wdata = d_wdata;
  assign i_rdata    = pmem_rdata;
  assign d_rdata    = pmem_rdata;

endmodule : pmem_arbiter

// File: tb/tb_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmem_arbiter
//   Directed bench for pmem_arbiter. Stimulus tasks push the transfer each
//   client should see onto a scoreboard queue in the order the arbiter must
//   serve them; a negedge monitor pops an entry on every client resp and
//   compares client, address, strobes, write data and returned line.
//   Honours PMEM_ARB_ROUND_ROBIN_EN for the contested-grant order.
// -----------------------------------------------------------------------------
module tb_pmem_arbiter;
  import pmem_arb_types::*;

  localparam int AW = 32;
  localparam int LW = 256;

  typedef logic [LW-1:0] line_t;
  typedef logic [AW-1:0] addr_t;

  typedef struct {
    logic  is_d;
    logic  is_wr;
    addr_t addr;
    line_t wdata;
    line_t rdata;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  addr_t i_addr;
  logic  i_read;
  line_t i_rdata;
  logic  i_resp;
  addr_t d_addr;
  logic  d_read;
  logic  d_write;
  line_t d_wdata;
  line_t d_rdata;
  logic  d_resp;
  addr_t pmem_addr;
  logic  pmem_read;
  logic  pmem_write;
  line_t pmem_wdata;
  line_t pmem_rdata;
  logic  pmem_resp;

  int    n_checks = 0;
  int    n_bad    = 0;
  exp_t  exp_q[$];

  always #5 clk = ~clk;

  pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_addr     (i_addr),
    .i_read     (i_read),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_addr     (d_addr),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_addr  (pmem_addr),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  task automatic check(input string tag, input line_t got, input line_t exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic is_d, input logic is_wr, input addr_t addr,
                                  input line_t wdata, input line_t rdata);
    exp_t e;
    e.is_d  = is_d;
    e.is_wr = is_wr;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = rdata;
    return e;
  endfunction

  // Scoreboard: every client resp must match the oldest expected transfer.
  always @(negedge clk) begin
    if (!rst && (i_resp || d_resp)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", line_t'({i_resp, d_resp}), line_t'(2'b00));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_client", line_t'({i_resp, d_resp}), line_t'(e.is_d ? 2'b01 : 2'b10));
        check("pmem_addr",   line_t'(pmem_addr),  line_t'(e.addr));
        check("pmem_write",  line_t'(pmem_write), line_t'(e.is_wr));
        check("pmem_read",   line_t'(pmem_read),  line_t'(!e.is_wr));
        if (e.is_wr) check("pmem_wdata", pmem_wdata, e.wdata);
        check("client_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
      end
    end
  end

  // Memory model for one transfer. Called just after a rising edge; returns
  // the number of edges waited before a strobe appeared, holds the strobe for
  // lat cycles with pmem_resp in the last one, then checks the RELEASE cycle.
  task automatic run_service(input int lat, input line_t rdata, output int waited);
    waited = 0;
    while (!(pmem_read || pmem_write) && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("strobe_seen", line_t'(pmem_read | pmem_write), line_t'(1'b1));
    if (pmem_read || pmem_write) begin
      for (int k = 1; k <= lat; k++) begin
        if (k > 1) begin
          @(posedge clk); #1;
        end
        check("strobe_held", line_t'(pmem_read | pmem_write), line_t'(1'b1));
        if (k == lat) begin
          pmem_rdata = rdata;
          pmem_resp  = 1'b1;
        end
      end
      @(posedge clk); #1;
      pmem_resp  = 1'b0;
      pmem_rdata = {8{32'h0BAD_F00D}};
      check("release_quiet", line_t'({pmem_read, pmem_write, i_resp, d_resp}), line_t'(4'b0));
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam line_t R_I1  = {8{32'h1111_0001}};
  localparam line_t R_D1  = {8{32'h2222_0002}};
  localparam line_t R_D2  = {8{32'h3333_0003}};
  localparam line_t R_I2  = {8{32'h4444_0004}};
  localparam line_t R_RST = {8{32'h5555_0005}};
  localparam line_t R_B1  = {8{32'h6666_0006}};
  localparam line_t R_B2  = {8{32'h7777_0007}};
  localparam line_t R_B3  = {8{32'h8888_0008}};
  localparam line_t W_A5  = {32{8'hA5}};
  localparam line_t W_C3  = {16{16'hC33C}};
  localparam line_t SPUR  = {8{32'h9999_0009}};

  initial begin
    int w;
    rst        = 1'b1;
    i_addr     = '0;
    i_read     = 1'b0;
    d_addr     = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", line_t'({pmem_read, pmem_write, i_resp, d_resp}), line_t'(4'b0));
    @(posedge clk); #1;
    rst = 1'b0;

    // I-side read, memory answers in the third strobe cycle.
    @(posedge clk); #1;
    i_addr = 32'h0000_1000;
    i_read = 1'b1;
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h0000_1000, '0, R_I1));
    run_service(3, R_I1, w);
    check("i_arb_latency", line_t'(w), line_t'(1));
    i_read = 1'b0;

    // D-side eviction with an all-0xA5 line.
    @(posedge clk); #1;
    d_addr  = 32'h0000_2040;
    d_wdata = W_A5;
    d_write = 1'b1;
    exp_q.push_back(mk_exp(1'b1, 1'b1, 32'h0000_2040, W_A5, R_D1));
    run_service(2, R_D1, w);
    check("d_arb_latency", line_t'(w), line_t'(1));
    d_write = 1'b0;

    // Read and write together behave as a write; single-cycle memory.
    @(posedge clk); #1;
    d_addr  = 32'h0000_3080;
    d_wdata = W_C3;
    d_read  = 1'b1;
    d_write = 1'b1;
    exp_q.push_back(mk_exp(1'b1, 1'b1, 32'h0000_3080, W_C3, R_D2));
    run_service(1, R_D2, w);
    d_read  = 1'b0;
    d_write = 1'b0;

    // Spurious pmem_resp while idle: no resp, rdata still passes through.
    @(posedge clk); #1;
    pmem_rdata = SPUR;
    pmem_resp  = 1'b1;
    @(negedge clk);
    check("spur_resp", line_t'({i_resp, d_resp}), line_t'(2'b00));
    check("spur_i_rdata", i_rdata, SPUR);
    check("spur_d_rdata", d_rdata, SPUR);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    i_addr    = 32'h0000_10C0;
    i_read    = 1'b1;
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h0000_10C0, '0, R_I2));
    run_service(1, R_I2, w);
    check("spur_still_idle", line_t'(w), line_t'(1));
    i_read = 1'b0;

    // Reset in the middle of a D-side read; request re-served afterwards.
    @(posedge clk); #1;
    d_addr = 32'h0000_4000;
    d_read = 1'b1;
    exp_q.push_back(mk_exp(1'b1, 1'b0, 32'h0000_4000, '0, R_RST));
    @(posedge clk); #1;
    check("pre_rst_strobe", line_t'(pmem_read), line_t'(1'b1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_quiet", line_t'({pmem_read, pmem_write, i_resp, d_resp}), line_t'(4'b0));
    rst = 1'b0;
    run_service(2, R_RST, w);
    check("reserve_latency", line_t'(w), line_t'(1));
    d_read = 1'b0;

    // Contested requests, D side re-requesting straight after its resp.
    apply_reset();
    @(posedge clk); #1;
    i_addr = 32'h0000_5000;
    i_read = 1'b1;
    d_addr = 32'h0000_6000;
    d_read = 1'b1;
    exp_q.push_back(mk_exp(1'b1, 1'b0, 32'h0000_6000, '0, R_B1));
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h0000_5000, '0, R_B2));
`else
    exp_q.push_back(mk_exp(1'b1, 1'b0, 32'h0000_6040, '0, R_B2));
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h0000_5000, '0, R_B3));
`endif
    run_service(2, R_B1, w);
    check("b2b_first_latency", line_t'(w), line_t'(1));
    d_addr = 32'h0000_6040;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    exp_q.push_back(mk_exp(1'b1, 1'b0, 32'h0000_6040, '0, R_B3));
`endif
    run_service(1, R_B2, w);
    check("b2b_gap_second", line_t'(w), line_t'(2));
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    i_read = 1'b0;
`else
    d_read = 1'b0;
`endif
    run_service(1, R_B3, w);
    check("b2b_gap_third", line_t'(w), line_t'(2));
    i_read = 1'b0;
    d_read = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", line_t'(exp_q.size()), line_t'(0));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule : tb_pmem_arbiter
